// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU control path, the boot/debug loader, the
// memory macro and the arbiter that sequences the single memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_lock;
  logic              ldr_gnt;
  logic              ldr_done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the unified memory port, with
// programmable wait states and a loader lock that blocks the CPU.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  state_t            state;
  logic [3:0]        cnt;
  logic              last;
  logic              owner;

  logic              cpu_ok;
  logic              any_req;
  logic              pick_ldr;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A tie goes to whoever did not win last; last resets to LDR so the CPU wins first.
  always_comb begin
    cpu_ok    = bus.cpu_req & ~bus.ldr_lock;
    any_req   = cpu_ok | bus.ldr_req;
    pick_ldr  = bus.ldr_req & (~cpu_ok | (last == OWN_CPU));
    sel_we    = pick_ldr ? bus.ldr_we    : bus.cpu_we;
    sel_addr  = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
    sel_wdata = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= OWN_LDR;
      owner         <= OWN_CPU;
      bus.cpu_gnt   <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.ldr_gnt   <= 1'b0;
      bus.ldr_done  <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= pick_ldr;
            bus.cpu_gnt   <= ~pick_ldr;
            bus.ldr_gnt   <= pick_ldr;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.busy      <= 1'b1;
            cnt           <= 4'(WAIT);
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // mem_rdata is only valid now, when the wait count has run out
            if (!bus.mem_we) bus.rdata <= bus.mem_rdata;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.cpu_done <= (owner == OWN_CPU);
            bus.ldr_done <= (owner == OWN_LDR);
            state        <= RESP;
          end
        end
        RESP: begin
          last         <= owner;
          bus.cpu_gnt  <= 1'b0;
          bus.ldr_gnt  <= 1'b0;
          bus.cpu_done <= 1'b0;
          bus.ldr_done <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover WAIT = 1, 3 and 0.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {ifa.cpu_req, ifa.cpu_we, ifa.ldr_req, ifa.ldr_we, ifa.ldr_lock} = '0;
    {ifb.cpu_req, ifb.cpu_we, ifb.ldr_req, ifb.ldr_we, ifb.ldr_lock} = '0;
    {ifc.cpu_req, ifc.cpu_we, ifc.ldr_req, ifc.ldr_we, ifc.ldr_lock} = '0;
    ifa.cpu_addr = '0; ifa.cpu_wdata = '0; ifa.ldr_addr = '0; ifa.ldr_wdata = '0; ifa.mem_rdata = '0;
    ifb.cpu_addr = '0; ifb.cpu_wdata = '0; ifb.ldr_addr = '0; ifb.ldr_wdata = '0; ifb.mem_rdata = '0;
    ifc.cpu_addr = '0; ifc.cpu_wdata = '0; ifc.ldr_addr = '0; ifc.ldr_wdata = '0; ifc.mem_rdata = '0;
    cyc(); cyc();
    n_cmp++;
    if ({ifa.cpu_gnt, ifa.ldr_gnt, ifa.cpu_done, ifa.ldr_done, ifa.busy, ifa.mem_en, ifa.mem_we} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, want 0000000",
               {ifa.cpu_gnt, ifa.ldr_gnt, ifa.cpu_done, ifa.ldr_done, ifa.busy, ifa.mem_en, ifa.mem_we});
    end
    n_cmp++;
    if ({ifa.rdata, ifa.mem_addr, ifa.mem_wdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, want all 0", ifa.rdata, ifa.mem_addr, ifa.mem_wdata);
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if ({ifa.busy, ifb.busy, ifc.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b, want 000", {ifa.busy, ifb.busy, ifc.busy});
    end
  endtask

  task automatic test_cpu_read();
    int en_cnt = 0, done_at = -1, done_cnt = 0, ldr_seen = 0, addr_bad = 0;
    ifa.mem_rdata = 32'hDEADBEEF;
    ifa.cpu_we = 1'b0; ifa.cpu_addr = 32'h10; ifa.cpu_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ifa.mem_en) begin
        en_cnt++;
        if (ifa.mem_addr !== 32'h10) addr_bad++;
      end
      if (ifa.ldr_gnt) ldr_seen++;
      if (ifa.cpu_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        ifa.cpu_req = 1'b0;
      end
    end
    n_cmp++;
    if (en_cnt !== 2) begin n_bad++; $display("FAIL rd_en_cycles: got %0d, want 2", en_cnt); end
    n_cmp++;
    if (addr_bad !== 0) begin n_bad++; $display("FAIL rd_addr: %0d cycles with wrong mem_addr, want 0", addr_bad); end
    n_cmp++;
    if (done_at !== 2) begin n_bad++; $display("FAIL rd_latency: done at edge %0d, want 2", done_at); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL rd_done_width: got %0d, want 1", done_cnt); end
    n_cmp++;
    if (ifa.rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata: got %h, want deadbeef", ifa.rdata); end
    n_cmp++;
    if (ldr_seen !== 0) begin n_bad++; $display("FAIL rd_ldr_gnt: high %0d cycles, want 0", ldr_seen); end
  endtask

  task automatic test_round_robin();
    int order[4];
    int want[4] = '{0, 1, 0, 1};
    int ng = 0, clash = 0;
    logic pc = 1'b0, pl = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ifa.cpu_we = 1'b0; ifa.ldr_we = 1'b0;
    ifa.cpu_req = 1'b1; ifa.ldr_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (ifa.cpu_gnt && ifa.ldr_gnt) clash++;
      if (ifa.cpu_done && ifa.ldr_done) clash++;
      if (ng < 4 && ifa.cpu_gnt && !pc) begin order[ng] = 0; ng++; end
      if (ng < 4 && ifa.ldr_gnt && !pl) begin order[ng] = 1; ng++; end
      pc = ifa.cpu_gnt; pl = ifa.ldr_gnt;
      if (ng == 4) begin ifa.cpu_req = 1'b0; ifa.ldr_req = 1'b0; end
    end
    n_cmp++;
    if (ng !== 4) begin n_bad++; $display("FAIL rr_grants: got %0d grants, want 4", ng); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i < ng && order[i] !== want[i]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d (0=CPU 1=LDR)", i, order[i], want[i]);
      end
    end
    n_cmp++;
    if (clash !== 0) begin n_bad++; $display("FAIL rr_exclusive: %0d overlap cycles, want 0", clash); end
  endtask

  task automatic test_lock();
    int gnt_seen = 0, busy_seen = 0;
    ifa.mem_rdata = 32'h0BADF00D;
    ifa.ldr_lock = 1'b1; ifa.ldr_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_addr = 32'h8; ifa.cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ifa.cpu_gnt) gnt_seen++;
      if (ifa.busy) busy_seen++;
    end
    n_cmp++;
    if (gnt_seen !== 0) begin n_bad++; $display("FAIL lock_gnt: high %0d cycles, want 0", gnt_seen); end
    n_cmp++;
    if (busy_seen !== 0) begin n_bad++; $display("FAIL lock_busy: high %0d cycles, want 0", busy_seen); end
    ifa.ldr_lock = 1'b0;
    cyc();
    n_cmp++;
    if (ifa.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL lock_release: cpu_gnt=%b, want 1", ifa.cpu_gnt); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ifa.cpu_done) ifa.cpu_req = 1'b0;
    end
  endtask

  task automatic test_ldr_write();
    int match = 0, en_cnt = 0, done_cnt = 0, cpu_seen = 0;
    ifa.mem_rdata = 32'h55555555;
    ifa.ldr_we = 1'b1; ifa.ldr_addr = 32'h4; ifa.ldr_wdata = 32'h1234; ifa.ldr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ifa.mem_en) en_cnt++;
      if (ifa.mem_en && ifa.mem_we && ifa.mem_addr == 32'h4 && ifa.mem_wdata == 32'h1234) match++;
      if (ifa.cpu_gnt) cpu_seen++;
      if (ifa.ldr_done) begin done_cnt++; ifa.ldr_req = 1'b0; end
    end
    ifa.ldr_we = 1'b0;
    n_cmp++;
    if (match !== 2) begin n_bad++; $display("FAIL wr_bus: %0d matching write cycles, want 2", match); end
    n_cmp++;
    if (en_cnt !== 2) begin n_bad++; $display("FAIL wr_en_cycles: got %0d, want 2", en_cnt); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL wr_done: got %0d pulses, want 1", done_cnt); end
    n_cmp++;
    if (ifa.rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL wr_rdata_held: got %h, want 0badf00d", ifa.rdata); end
    n_cmp++;
    if (cpu_seen !== 0) begin n_bad++; $display("FAIL wr_cpu_gnt: high %0d cycles, want 0", cpu_seen); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0, g_at = -1, d_at = -1;
    ifb.mem_rdata = 32'h77; ifb.cpu_we = 1'b0; ifb.cpu_addr = 32'h20; ifb.cpu_req = 1'b1;
    cyc();
    n_cmp++;
    if (ifb.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_grant: cpu_gnt=%b, want 1", ifb.cpu_gnt); end
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ifb.mem_en, ifb.cpu_gnt, ifb.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL rm_async: en/gnt/busy=%b, want 000", {ifb.mem_en, ifb.cpu_gnt, ifb.busy});
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (ifb.cpu_done) done_cnt++;
    end
    rst_n = 1'b1;
    n_cmp++;
    if (done_cnt !== 0) begin n_bad++; $display("FAIL rm_no_done: %0d pulses, want 0", done_cnt); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ifb.cpu_gnt && g_at < 0) g_at = i;
      if (ifb.cpu_done && d_at < 0) begin d_at = i; ifb.cpu_req = 1'b0; end
    end
    n_cmp++;
    if (g_at !== 0 || d_at !== 4) begin n_bad++; $display("FAIL rm_recover: grant %0d done %0d, want 0 and 4", g_at, d_at); end
    n_cmp++;
    if (ifb.rdata !== 32'h77) begin n_bad++; $display("FAIL rm_rdata: got %h, want 00000077", ifb.rdata); end
  endtask

  task automatic test_back_to_back();
    int g[2] = '{-1, -1};
    int d[2] = '{-1, -1};
    logic [31:0] ga[2];
    logic [31:0] rd[2];
    int ng = 0, nd = 0;
    logic pc = 1'b0;
    ifc.mem_rdata = 32'hA0; ifc.cpu_we = 1'b0; ifc.cpu_addr = 32'h0; ifc.cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ifc.cpu_gnt && !pc && ng < 2) begin g[ng] = i; ga[ng] = ifc.mem_addr; ng++; end
      pc = ifc.cpu_gnt;
      if (ifc.cpu_done && nd < 2) begin
        d[nd] = i; rd[nd] = ifc.rdata; nd++;
        ifc.cpu_addr = 32'h4; ifc.mem_rdata = 32'hB4;
        if (nd == 2) ifc.cpu_req = 1'b0;
      end
    end
    n_cmp++;
    if (g[0] !== 0 || d[0] !== 1) begin n_bad++; $display("FAIL b2b_first: grant %0d done %0d, want 0 and 1", g[0], d[0]); end
    n_cmp++;
    if (g[1] !== 3 || d[1] !== 4) begin n_bad++; $display("FAIL b2b_second: grant %0d done %0d, want 3 and 4", g[1], d[1]); end
    n_cmp++;
    if (ng == 2 && (ga[0] !== 32'h0 || ga[1] !== 32'h4)) begin
      n_bad++; $display("FAIL b2b_addr: got %h %h, want 0 and 4", ga[0], ga[1]);
    end
    n_cmp++;
    if (nd == 2 && (rd[0] !== 32'hA0 || rd[1] !== 32'hB4)) begin
      n_bad++; $display("FAIL b2b_rdata: got %h %h, want a0 and b4", rd[0], rd[1]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_lock();
    test_ldr_write();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
